decode_queue: RTL and testbench

Parametrised, buffered RV32 instruction decoder. It accepts a fetched instruction and PC over a valid/ready handshake and decodes them in the same cycle. The decoded fields are stored in a DEPTH-entry FIFO and presented with their own valid/ready handshake. The block sits between fetch and issue, absorbs issue-side backpressure, and flags illegal encodings so that downstream logic can trap.

---
 rtl/decode_queue.sv | 196 +++++++++++++++++++
 tb/tb_decode_queue.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32 instruction decoder feeding a DEPTH-entry FIFO of decoded fields.
// Sits between fetch and issue; illegal encodings are queued and flagged.
module decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter bit          RV32E = 1'b0,
  parameter bit          M_EXT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [9:0]  out_class,
  output logic [31:0] out_imm,
  output logic        out_imm_valid,
  output logic [4:0]  out_rs1,
  output logic        out_rs1_valid,
  output logic [4:0]  out_rs2,
  output logic        out_rs2_valid,
  output logic [4:0]  out_rd,
  output logic        out_rd_valid,
  output logic [2:0]  out_funct3,
  output logic        out_funct3_valid,
  output logic [6:0]  out_funct7,
  output logic        out_funct7_valid,
  output logic        out_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  cls;
    logic [31:0] imm;
    logic        imm_v;
    logic [4:0]  rs1;
    logic        rs1_v;
    logic [4:0]  rs2;
    logic        rs2_v;
    logic [4:0]  rd;
    logic        rd_v;
    logic [2:0]  f3;
    logic        f3_v;
    logic [6:0]  f7;
    logic        f7_v;
    logic        illegal;
  } entry_t;

  entry_t          dec;
  fmt_e            fmt;
  logic            r_bad;
  logic            e_bad;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    dec     = '0;
    fmt     = FMT_NONE;
    r_bad   = 1'b0;
    e_bad   = 1'b0;
    dec.pc  = in_pc;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    dec.f3  = in_instr[14:12];
    dec.f7  = in_instr[31:25];

    case (in_instr[6:0])
      7'b0110011: begin dec.cls[0] = 1'b1; fmt = FMT_R; end
      7'b0010011: begin dec.cls[1] = 1'b1; fmt = FMT_I; end
      7'b0000011: begin dec.cls[2] = 1'b1; fmt = FMT_I; end
      7'b0100011: begin dec.cls[3] = 1'b1; fmt = FMT_S; end
      7'b1100011: begin dec.cls[4] = 1'b1; fmt = FMT_B; end
      7'b1101111: begin dec.cls[5] = 1'b1; fmt = FMT_J; end
      7'b1100111: begin dec.cls[6] = 1'b1; fmt = FMT_I; end
      7'b0110111: begin dec.cls[7] = 1'b1; fmt = FMT_U; end
      7'b0010111: begin dec.cls[8] = 1'b1; fmt = FMT_U; end
      7'b1110011: begin dec.cls[9] = 1'b1; fmt = FMT_I; end
      default:    fmt = FMT_NONE;
    endcase

    case (fmt)
      FMT_R: begin
        dec.rs1_v = 1'b1; dec.rs2_v = 1'b1; dec.rd_v = 1'b1;
        dec.f3_v  = 1'b1; dec.f7_v  = 1'b1;
      end
      FMT_I: begin
        dec.imm   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.imm_v = 1'b1; dec.rs1_v = 1'b1; dec.rd_v = 1'b1; dec.f3_v = 1'b1;
        // Shift-immediates carry their arithmetic/logical selector in funct7.
        dec.f7_v  = dec.cls[1] && (dec.f3 == 3'b001 || dec.f3 == 3'b101);
      end
      FMT_S: begin
        dec.imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.imm_v = 1'b1; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1; dec.f3_v = 1'b1;
      end
      FMT_B: begin
        dec.imm   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        dec.imm_v = 1'b1; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1; dec.f3_v = 1'b1;
      end
      FMT_U: begin
        dec.imm   = {in_instr[31:12], 12'b0};
        dec.imm_v = 1'b1; dec.rd_v = 1'b1;
      end
      FMT_J: begin
        dec.imm   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        dec.imm_v = 1'b1; dec.rd_v = 1'b1;
      end
      default: ;
    endcase

    r_bad = (fmt == FMT_R) &&
            !((dec.f7 == 7'h00) ||
              (dec.f7 == 7'h20 && (dec.f3 == 3'b000 || dec.f3 == 3'b101)) ||
              (M_EXT && dec.f7 == 7'h01));
    e_bad = RV32E && ((dec.rs1_v && dec.rs1[4]) ||
                      (dec.rs2_v && dec.rs2[4]) ||
                      (dec.rd_v  && dec.rd[4]));
    dec.illegal = (in_instr[1:0] != 2'b11) || (fmt == FMT_NONE) || r_bad || e_bad;
  end

  assign in_ready  = rst && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else if (flush) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; out_valid qualifies it, and leaving it
  // unreset lets it map onto plain RAM/flops without reset routing.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  entry_t head;
  assign head = mem[rptr];

  assign out_pc           = head.pc;
  assign out_class        = head.cls;
  assign out_imm          = head.imm;
  assign out_imm_valid    = head.imm_v;
  assign out_rs1          = head.rs1;
  assign out_rs1_valid    = head.rs1_v;
  assign out_rs2          = head.rs2;
  assign out_rs2_valid    = head.rs2_v;
  assign out_rd           = head.rd;
  assign out_rd_valid     = head.rd_v;
  assign out_funct3       = head.f3;
  assign out_funct3_valid = head.f3_v;
  assign out_funct7       = head.f7;
  assign out_funct7_valid = head.f7_v;
  assign out_illegal      = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: two instances (base ISA, and RV32E+M)
// share stimulus and are compared against a queue-based reference model.
module tb_decode_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  cls;
    logic [31:0] imm;
    logic        imm_v;
    logic [4:0]  rs1;
    logic        rs1_v;
    logic [4:0]  rs2;
    logic        rs2_v;
    logic [4:0]  rd;
    logic        rd_v;
    logic [2:0]  f3;
    logic        f3_v;
    logic [6:0]  f7;
    logic        f7_v;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  cls;
    logic        imm_v;
    logic [31:0] imm;
    logic        ill_base;
    logic        ill_alt;
  } vec_t;

  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic rdy [2];
  logic vld [2];
  dec_t act [2];

  int n_checks = 0;
  int n_fail   = 0;
  item_t mq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] w_pc, w_imm;
    logic [9:0]  w_cls;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_imm_v, w_rs1_v, w_rs2_v, w_rd_v, w_f3_v, w_f7_v, w_ill;
    logic        w_rdy, w_vld;

    decode_queue #(.DEPTH(DEPTH), .RV32E(g == 1), .M_EXT(g == 1)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (w_rdy),
      .in_instr         (in_instr),
      .in_pc            (in_pc),
      .out_valid        (w_vld),
      .out_ready        (out_ready),
      .out_pc           (w_pc),
      .out_class        (w_cls),
      .out_imm          (w_imm),
      .out_imm_valid    (w_imm_v),
      .out_rs1          (w_rs1),
      .out_rs1_valid    (w_rs1_v),
      .out_rs2          (w_rs2),
      .out_rs2_valid    (w_rs2_v),
      .out_rd           (w_rd),
      .out_rd_valid     (w_rd_v),
      .out_funct3       (w_f3),
      .out_funct3_valid (w_f3_v),
      .out_funct7       (w_f7),
      .out_funct7_valid (w_f7_v),
      .out_illegal      (w_ill)
    );

    assign rdy[g] = w_rdy;
    assign vld[g] = w_vld;
    assign act[g] = {w_pc, w_cls, w_imm, w_imm_v, w_rs1, w_rs1_v, w_rs2, w_rs2_v,
                     w_rd, w_rd_v, w_f3, w_f3_v, w_f7, w_f7_v, w_ill};
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] s;
    s = v << (32 - bits);
    return s >>> (32 - bits);
  endfunction

  // Reference decode: find the opcode's class, look up its format letter,
  // then apply the format's field rules.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input bit e, input bit m);
    dec_t  d;
    int    idx;
    string fmts;
    byte   f;
    d     = '0;
    idx   = -1;
    fmts  = "RIISBJIUUI";
    d.pc  = pc;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    d.f3  = ins[14:12];
    d.f7  = ins[31:25];
    for (int k = 0; k < 10; k++) if (ins[6:0] == OPS[k]) idx = k;
    f = (idx >= 0) ? fmts.getc(idx) : "-";
    if (idx >= 0) d.cls = 10'(1) << idx;
    case (f)
      "R": begin
        {d.rs1_v, d.rs2_v, d.rd_v, d.f3_v, d.f7_v} = '1;
      end
      "I": begin
        d.imm = sext(ins >> 20, 12);
        {d.imm_v, d.rs1_v, d.rd_v, d.f3_v} = '1;
        d.f7_v = (idx == 1) && (d.f3 == 3'd1 || d.f3 == 3'd5);
      end
      "S": begin
        d.imm = sext({ins[31:25], ins[11:7]}, 12);
        {d.imm_v, d.rs1_v, d.rs2_v, d.f3_v} = '1;
      end
      "B": begin
        d.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        {d.imm_v, d.rs1_v, d.rs2_v, d.f3_v} = '1;
      end
      "U": begin
        d.imm = ins & 32'hFFFF_F000;
        {d.imm_v, d.rd_v} = '1;
      end
      "J": begin
        d.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        {d.imm_v, d.rd_v} = '1;
      end
      default: ;
    endcase
    d.ill = (ins[1:0] != 2'b11) || (idx < 0);
    if (f == "R" && !(d.f7 == 7'h00 || (d.f7 == 7'h20 && (d.f3 == 3'd0 || d.f3 == 3'd5)) ||
                      (m && d.f7 == 7'h01)))
      d.ill = 1'b1;
    if (e && ((d.rs1_v && d.rs1 >= 16) || (d.rs2_v && d.rs2 >= 16) || (d.rd_v && d.rd >= 16)))
      d.ill = 1'b1;
    return d;
  endfunction

  task automatic check_dec(input string tag, input dec_t a, input dec_t x);
    check({tag, ".pc"},     a.pc,    x.pc);
    check({tag, ".class"},  a.cls,   x.cls);
    check({tag, ".imm_v"},  a.imm_v, x.imm_v);
    if (x.imm_v) check({tag, ".imm"}, a.imm, x.imm);
    check({tag, ".rs1_v"},  a.rs1_v, x.rs1_v);
    check({tag, ".rs2_v"},  a.rs2_v, x.rs2_v);
    check({tag, ".rd_v"},   a.rd_v,  x.rd_v);
    check({tag, ".f3_v"},   a.f3_v,  x.f3_v);
    check({tag, ".f7_v"},   a.f7_v,  x.f7_v);
    check({tag, ".rs1"},    a.rs1,   x.rs1);
    check({tag, ".rs2"},    a.rs2,   x.rs2);
    check({tag, ".rd"},     a.rd,    x.rd);
    check({tag, ".f3"},     a.f3,    x.f3);
    check({tag, ".f7"},     a.f7,    x.f7);
    check({tag, ".illegal"}, a.ill,  x.ill);
  endtask

  // Compare handshake state and head payload of both instances to the model.
  task automatic check_state(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s.in_ready[%0d]", tag, g), rdy[g], rst && (mq.size() < DEPTH));
      check($sformatf("%s.out_valid[%0d]", tag, g), vld[g], mq.size() != 0);
      if (mq.size() != 0 && vld[g] === 1'b1)
        check_dec($sformatf("%s.head[%0d]", tag, g), act[g],
                  ref_decode(mq[0].instr, mq[0].pc, g == 1, g == 1));
    end
  endtask

  // One clock cycle: predict the model transition, take the edge, compare.
  task automatic tick(input string tag);
    bit push, pop;
    push = in_valid && rst && (mq.size() < DEPTH) && !flush;
    pop  = (mq.size() != 0) && out_ready && !flush;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{instr: in_instr, pc: in_pc});
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  vec_t tab[$];

  initial begin
    tab.push_back('{32'h01700793, 10'h002, 1'b1, 32'h0000_0017, 1'b0, 1'b0}); // addi x15,x0,23
    tab.push_back('{32'hFE208CE3, 10'h010, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0}); // beq x1,x2,-8
    tab.push_back('{32'h00208A33, 10'h001, 1'b0, 32'h0,         1'b0, 1'b1}); // add x20,x1,x2
    tab.push_back('{32'h022081B3, 10'h001, 1'b0, 32'h0,         1'b1, 1'b0}); // mul x3,x1,x2
    tab.push_back('{32'h123452B7, 10'h080, 1'b1, 32'h1234_5000, 1'b0, 1'b0}); // lui x5
    tab.push_back('{32'hFFFFF097, 10'h100, 1'b1, 32'hFFFF_F000, 1'b0, 1'b0}); // auipc x1
    tab.push_back('{32'hFFDFF0EF, 10'h020, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0}); // jal x1,-4
    tab.push_back('{32'h0020A423, 10'h008, 1'b1, 32'h0000_0008, 1'b0, 1'b0}); // sw x2,8(x1)
    tab.push_back('{32'hFFF02F83, 10'h004, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1}); // lw x31,-1(x0)
    tab.push_back('{32'h00008067, 10'h040, 1'b1, 32'h0,         1'b0, 1'b0}); // jalr x0,0(x1)
    tab.push_back('{32'h00000073, 10'h200, 1'b1, 32'h0,         1'b0, 1'b0}); // ecall
    tab.push_back('{32'h407352B3, 10'h001, 1'b0, 32'h0,         1'b0, 1'b0}); // sra x5,x6,x7
    tab.push_back('{32'h40001033, 10'h001, 1'b0, 32'h0,         1'b1, 1'b1}); // f7=0x20, f3=001
    tab.push_back('{32'h0000007F, 10'h000, 1'b0, 32'h0,         1'b1, 1'b1}); // unknown opcode
    tab.push_back('{32'h00000001, 10'h000, 1'b0, 32'h0,         1'b1, 1'b1}); // compressed
    tab.push_back('{32'h00309093, 10'h002, 1'b1, 32'h0000_0003, 1'b0, 1'b0}); // slli x1,x1,3

    // Reset state.
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset.out_valid", vld[g], 1'b0);
      check("reset.in_ready", rdy[g], 1'b0);
    end
    rst = 1'b1;
    #1;
    check("release.in_ready", rdy[0], 1'b1);
    @(negedge clk);
    check_state("idle");

    // Table vectors: each pushed into an empty queue, checked one cycle later.
    foreach (tab[i]) begin
      offer(tab[i].instr, 32'h1000 + 32'(i) * 4);
      out_ready = 1'b0;
      tick("table.push");
      for (int g = 0; g < 2; g++) begin
        check($sformatf("table%0d.valid", i), vld[g], 1'b1);
        check($sformatf("table%0d.class", i), act[g].cls, tab[i].cls);
        check($sformatf("table%0d.imm_v", i), act[g].imm_v, tab[i].imm_v);
        if (tab[i].imm_v) check($sformatf("table%0d.imm", i), act[g].imm, tab[i].imm);
        check($sformatf("table%0d.illegal[%0d]", i, g), act[g].ill,
              (g == 0) ? tab[i].ill_base : tab[i].ill_alt);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick("table.pop");
    end

    // Backpressure: A, B, C back-to-back with the consumer stalled.
    out_ready = 1'b0;
    offer(32'h00100093, 32'hA0); tick("bp.A");
    offer(32'h00200113, 32'hB0); tick("bp.B");
    check("bp.full", rdy[0], 1'b0);
    offer(32'h00300193, 32'hC0); tick("bp.C_stall1");
    tick("bp.C_stall2");
    check("bp.still_full", rdy[0], 1'b0);
    check("bp.head_A", act[0].pc, 32'hA0);
    out_ready = 1'b1;
    tick("bp.pop1");
    check("bp.head_B", act[0].pc, 32'hB0);
    tick("bp.pop2");
    check("bp.head_C", act[0].pc, 32'hC0);
    in_valid = 1'b0;
    tick("bp.pop3");
    check("bp.empty", vld[0], 1'b0);

    // Flush with two entries queued and a simultaneous push offered.
    out_ready = 1'b0;
    offer(32'h00500293, 32'hD0); tick("fl.fill1");
    offer(32'h00600313, 32'hD4); tick("fl.fill2");
    offer(32'h00700393, 32'hD8);
    flush = 1'b1;
    tick("fl.flush");
    check("fl.out_valid", vld[0], 1'b0);
    check("fl.out_valid_alt", vld[1], 1'b0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick("fl.after");

    // Flush on an empty queue must also drop the same-cycle push.
    offer(32'h00800413, 32'hDC);
    flush = 1'b1;
    tick("fl.empty_push");
    flush    = 1'b0;
    in_valid = 1'b0;
    tick("fl.empty_after");
    check("fl.dropped_push", vld[0], 1'b0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    offer(32'h01700793, 32'hE0); tick("rs.fill");
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rs.async_out_valid", vld[g], 1'b0);
      check("rs.async_in_ready", rdy[g], 1'b0);
    end
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rs.release_in_ready", rdy[0], 1'b1);
    offer(32'h01700793, 32'hE4);
    tick("rs.push");
    check("rs.reemerge_valid", vld[0], 1'b1);
    check("rs.reemerge_pc", act[0].pc, 32'hE4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick("rs.drain");

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = OPS[$urandom_range(0, 9)];
      if (ins[6:0] == 7'h33 && $urandom_range(0, 1) == 1)
        ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h01;
      if ($urandom_range(0, 1) == 1) ins[24] = 1'b0;
      offer(ins, $urandom & 32'hFFFF_FFFC);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
